// File: rtl/traffic_sensor_frontend.sv
// Loop-detector front end: debounce, per-approach vehicle queues,
// green-time departures, overflow and lamp-fault flags.
module traffic_sensor_frontend #(
    parameter int DEB_CYC    = 3,
    parameter int QW         = 5,
    parameter int DEPART_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          loop_north,
    input  logic          loop_east,
    input  logic          loop_south,
    input  logic          loop_west,
    input  logic [2:0]    ns_light,
    input  logic [2:0]    ew_light,
    input  logic [2:0]    sn_light,
    input  logic [2:0]    we_light,
    output logic          sensor_north,
    output logic          sensor_east,
    output logic          sensor_south,
    output logic          sensor_west,
    output logic [QW-1:0] q_north,
    output logic [QW-1:0] q_east,
    output logic [QW-1:0] q_south,
    output logic [QW-1:0] q_west,
    output logic          q_overflow,
    output logic          lamp_fault
);

    localparam logic [QW-1:0] QMAX  = '1;
    localparam logic [2:0]    RED   = 3'b001;
    localparam logic [2:0]    YEL   = 3'b010;
    localparam logic [2:0]    GRN   = 3'b100;
    localparam logic [4:0]    DEB_T = 5'(DEB_CYC);
    localparam logic [4:0]    DEP_T = 5'(DEPART_CYC);

    typedef enum logic [1:0] {IDLE, ARM, OCC, CLR} det_e;

    det_e          st    [4];
    det_e          st_n  [4];
    logic [3:0]    cnt   [4];
    logic [3:0]    cnt_n [4];
    logic [3:0]    dt    [4];
    logic [3:0]    dt_n  [4];
    logic [QW-1:0] q     [4];
    logic [QW-1:0] q_n   [4];
    logic [2:0]    light [4];
    logic [3:0]    loop_v;
    logic [3:0]    arr;
    logic [3:0]    dep;
    logic [3:0]    ovf_hit;
    logic [3:0]    sens;
    logic          lamp_bad;

    function automatic logic last_tick(input logic [3:0] c, input logic [4:0] t);
        return ({1'b0, c} + 5'd1) == t;
    endfunction

    assign loop_v   = {loop_west, loop_south, loop_east, loop_north};
    assign light[0] = ns_light;
    assign light[1] = ew_light;
    assign light[2] = sn_light;
    assign light[3] = we_light;

    // Detector next state: an edge is accepted after DEB_CYC identical samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_n[i]  = st[i];
            cnt_n[i] = cnt[i];
            arr[i]   = 1'b0;
            unique case (st[i])
                IDLE: if (loop_v[i]) begin
                    if (DEB_T == 5'd1) begin
                        st_n[i] = OCC;
                        arr[i]  = 1'b1;
                    end else begin
                        st_n[i]  = ARM;
                        cnt_n[i] = 4'd1;
                    end
                end
                ARM: if (!loop_v[i]) begin
                    st_n[i]  = IDLE;
                    cnt_n[i] = 4'd0;
                end else if (last_tick(cnt[i], DEB_T)) begin
                    st_n[i]  = OCC;
                    cnt_n[i] = 4'd0;
                    arr[i]   = 1'b1;
                end else begin
                    cnt_n[i] = cnt[i] + 4'd1;
                end
                OCC: if (!loop_v[i]) begin
                    if (DEB_T == 5'd1) begin
                        st_n[i] = IDLE;
                    end else begin
                        st_n[i]  = CLR;
                        cnt_n[i] = 4'd1;
                    end
                end
                CLR: if (loop_v[i]) begin
                    st_n[i]  = OCC;
                    cnt_n[i] = 4'd0;
                end else if (last_tick(cnt[i], DEB_T)) begin
                    st_n[i]  = IDLE;
                    cnt_n[i] = 4'd0;
                end else begin
                    cnt_n[i] = cnt[i] + 4'd1;
                end
                default: begin
                    st_n[i]  = IDLE;
                    cnt_n[i] = 4'd0;
                end
            endcase
        end
    end

    // Departure timing and queue arithmetic per approach.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dep[i]     = 1'b0;
            dt_n[i]    = 4'd0;
            q_n[i]     = q[i];
            ovf_hit[i] = 1'b0;
            if (light[i] == GRN && q[i] != '0) begin
                if (last_tick(dt[i], DEP_T)) dep[i]  = 1'b1;
                else                         dt_n[i] = dt[i] + 4'd1;
            end
            if (arr[i] && !dep[i]) begin
                if (q[i] == QMAX) ovf_hit[i] = 1'b1;
                else              q_n[i]     = q[i] + 1'b1;
            end else if (dep[i] && !arr[i]) begin
                q_n[i] = q[i] - 1'b1;
            end
        end
    end

    // Lamp check: every code must be one-hot legal and at most one green.
    always_comb begin
        logic [2:0] ng;
        lamp_bad = 1'b0;
        ng       = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (light[i] != RED && light[i] != YEL && light[i] != GRN)
                lamp_bad = 1'b1;
            if (light[i] == GRN) ng = ng + 3'd1;
        end
        if (ng >= 3'd2) lamp_bad = 1'b1;
    end

    // State, queues, presence and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= 4'd0;
                dt[i]  <= 4'd0;
                q[i]   <= '0;
            end
            sens       <= 4'd0;
            q_overflow <= 1'b0;
            lamp_fault <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st[i]   <= st_n[i];
                cnt[i]  <= cnt_n[i];
                dt[i]   <= dt_n[i];
                q[i]    <= q_n[i];
                sens[i] <= (q_n[i] != '0);
            end
            q_overflow <= q_overflow | (|ovf_hit);
            lamp_fault <= lamp_fault | lamp_bad;
        end
    end

    assign q_north      = q[0];
    assign q_east       = q[1];
    assign q_south      = q[2];
    assign q_west       = q[3];
    assign sensor_north = sens[0];
    assign sensor_east  = sens[1];
    assign sensor_south = sens[2];
    assign sensor_west  = sens[3];

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Scoreboard bench for traffic_sensor_frontend: directed scenarios
// followed by random loop/light traffic against a run-length model.
module tb_traffic_sensor_frontend;

    localparam int DEB  = 3;
    localparam int DEP  = 2;
    localparam int QMAX = 31;
    localparam logic [2:0] RED = 3'b001;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       loop_north, loop_east, loop_south, loop_west;
    logic [2:0] ns_light, ew_light, sn_light, we_light;
    logic       sensor_north, sensor_east, sensor_south, sensor_west;
    logic [4:0] q_north, q_east, q_south, q_west;
    logic       q_overflow, lamp_fault;

    traffic_sensor_frontend #(.DEB_CYC(DEB), .QW(5), .DEPART_CYC(DEP)) dut (
        .clk(clk), .rst(rst),
        .loop_north(loop_north), .loop_east(loop_east),
        .loop_south(loop_south), .loop_west(loop_west),
        .ns_light(ns_light), .ew_light(ew_light),
        .sn_light(sn_light), .we_light(we_light),
        .sensor_north(sensor_north), .sensor_east(sensor_east),
        .sensor_south(sensor_south), .sensor_west(sensor_west),
        .q_north(q_north), .q_east(q_east),
        .q_south(q_south), .q_west(q_west),
        .q_overflow(q_overflow), .lamp_fault(lamp_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][4:0] q;
        logic            ovf;
        logic            lf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: accepted level per loop, length of the current run
    // of samples disagreeing with it, green-cycle count, queue length.
    bit occ  [4];
    int run  [4];
    int gcnt [4];
    int mq   [4];
    bit movf, mlf;

    task automatic cmp(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    task automatic model_step();
        bit         lv [4];
        logic [2:0] lt [4];
        int         ng;
        exp_t       e;
        lv = '{loop_north, loop_east, loop_south, loop_west};
        lt = '{ns_light, ew_light, sn_light, we_light};
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                occ[i] = 0; run[i] = 0; gcnt[i] = 0; mq[i] = 0;
            end
            movf = 0;
            mlf  = 0;
        end else begin
            ng = 0;
            for (int i = 0; i < 4; i++) begin
                bit a, d;
                a = 0;
                d = 0;
                if (lv[i] != occ[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        occ[i] = lv[i];
                        run[i] = 0;
                        a = lv[i];
                    end
                end else begin
                    run[i] = 0;
                end
                if (lt[i] == GRN && mq[i] > 0) begin
                    gcnt[i]++;
                    if (gcnt[i] == DEP) begin
                        d = 1;
                        gcnt[i] = 0;
                    end
                end else begin
                    gcnt[i] = 0;
                end
                if (a && !d) begin
                    if (mq[i] == QMAX) movf = 1;
                    else mq[i]++;
                end else if (d && !a) begin
                    mq[i]--;
                end
                if (!(lt[i] inside {RED, YEL, GRN})) mlf = 1;
                if (lt[i] == GRN) ng++;
            end
            if (ng >= 2) mlf = 1;
        end
        for (int i = 0; i < 4; i++) e.q[i] = 5'(mq[i]);
        e.ovf = movf;
        e.lf  = mlf;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] aq [4];
            logic       as [4];
            e  = exp_q.pop_front();
            aq = '{q_north, q_east, q_south, q_west};
            as = '{sensor_north, sensor_east, sensor_south, sensor_west};
            for (int i = 0; i < 4; i++) begin
                cmp($sformatf("q[%0d]", i), aq[i], e.q[i]);
                cmp($sformatf("sensor[%0d]", i), as[i], e.q[i] != 0);
            end
            cmp("q_overflow", q_overflow, e.ovf);
            cmp("lamp_fault", lamp_fault, e.lf);
        end
    end

    task automatic vehicle_west();
        loop_west = 1; ticks(3);
        loop_west = 0; ticks(3);
    endtask

    initial begin
        rst = 1;
        loop_north = 1; loop_east = 0; loop_south = 0; loop_west = 0;
        ns_light = RED; ew_light = RED; sn_light = RED; we_light = RED;

        ticks(2);
        cmp("rst_q_north", q_north, 0);
        cmp("rst_sensor_north", sensor_north, 0);
        cmp("rst_flags", {q_overflow, lamp_fault}, 0);
        rst = 0;
        ticks(2);
        cmp("deb_not_yet", q_north, 0);
        tick();
        cmp("deb_q_north", q_north, 1);
        cmp("deb_sensor_north", sensor_north, 1);
        loop_north = 0; ticks(4);

        loop_east = 1; ticks(2);
        loop_east = 0; ticks(5);
        loop_east = 1; ticks(2);
        loop_east = 0; ticks(5);
        cmp("glitch_q_east", q_east, 0);
        loop_east = 1; ticks(4);
        loop_east = 0; ticks(1);
        loop_east = 1; ticks(3);
        loop_east = 0; ticks(4);
        cmp("dip_q_east", q_east, 1);
        ew_light = GRN; ticks(3);
        ew_light = RED; tick();
        cmp("drain_q_east", q_east, 0);

        ns_light = GRN; ticks(3);
        ns_light = RED; tick();
        cmp("drain_q_north", q_north, 0);
        for (int v = 0; v < 4; v++) begin
            loop_north = 1; ticks(4);
            loop_north = 0; ticks(4);
        end
        cmp("arr_q_north", q_north, 4);
        ns_light = GRN; tick();
        cmp("green1_q_north", q_north, 4);
        tick();
        cmp("green2_q_north", q_north, 3);
        ticks(4);
        cmp("green6_q_north", q_north, 1);
        ns_light = YEL; ticks(3);
        cmp("yellow_q_north", q_north, 1);
        ns_light = RED;

        for (int v = 0; v < 2; v++) begin
            loop_south = 1; ticks(4);
            loop_south = 0; ticks(4);
        end
        cmp("pre_q_south", q_south, 2);
        loop_south = 1; tick();
        sn_light = GRN; tick();
        tick();
        cmp("simul_q_south", q_south, 2);
        loop_south = 0; sn_light = RED; ticks(4);

        for (int v = 0; v < 32; v++) vehicle_west();
        cmp("sat_q_west", q_west, 31);
        cmp("sat_ovf", q_overflow, 1);
        we_light = GRN; ticks(4);
        cmp("sat_drain_q_west", q_west, 29);
        cmp("sat_ovf_sticky", q_overflow, 1);
        we_light = RED;

        rst = 1; tick();
        rst = 0; ticks(2);
        cmp("allred_no_fault", lamp_fault, 0);
        ns_light = GRN; ew_light = GRN; tick();
        ns_light = RED; ew_light = RED; ticks(2);
        cmp("two_green_fault", lamp_fault, 1);
        rst = 1; tick();
        rst = 0; ew_light = 3'b011; tick();
        ew_light = RED; ticks(2);
        cmp("illegal_code_fault", lamp_fault, 1);

        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) loop_north = ~loop_north;
            if ($urandom_range(0, 3) == 0) loop_east  = ~loop_east;
            if ($urandom_range(0, 3) == 0) loop_south = ~loop_south;
            if ($urandom_range(0, 3) == 0) loop_west  = ~loop_west;
            if ($urandom_range(0, 9) == 0) begin
                int g;
                logic [2:0] c [4];
                g = $urandom_range(0, 4);
                for (int i = 0; i < 4; i++)
                    c[i] = (i == g) ? GRN : ($urandom_range(0, 1) ? RED : YEL);
                if ($urandom_range(0, 19) == 0) c[$urandom_range(0, 3)] = 3'($urandom);
                if ($urandom_range(0, 19) == 0) c[$urandom_range(0, 3)] = GRN;
                ns_light = c[0]; ew_light = c[1]; sn_light = c[2]; we_light = c[3];
            end
            tick();
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_frontend.md
Name: traffic_sensor_frontend

Overview:
- Vehicle-detection front end that produces the per-approach presence signals `sensor_north/east/south/west` consumed by the traffic light controller.
- Debounces four raw loop-detector inputs and counts arriving vehicles into per-approach queues.
- Reads back the controller's light codes and retires one vehicle per DEPART_CYC cycles while that approach is green.
- Flags queue overflow and illegal light combinations.

Parameters:
- DEB_CYC, 3: consecutive identical loop samples required to accept a rising or falling loop edge (legal range 1..15).
- QW, 5: queue counter width; saturation value QMAX = 2^QW-1.
- DEPART_CYC, 2: cycles of green per departed vehicle (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- loop_north, loop_east, loop_south, loop_west  in  1 each  raw loop detectors, high while a vehicle is over the loop
- ns_light, ew_light, sn_light, we_light  in  3 each  controller light codes for the primary movement of each approach: red=3'b001, yellow=3'b010, green=3'b100
- sensor_north, sensor_east, sensor_south, sensor_west  out  1 each  high when that approach's queue is nonzero
- q_north, q_east, q_south, q_west  out  QW each  queued vehicle count
- q_overflow  out  1  sticky; an arrival was seen while a queue was at QMAX
- lamp_fault  out  1  sticky; illegal light code or more than one approach green

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - all q_* = 0, sensor_* = 0, q_overflow = 0, lamp_fault = 0;
  - all detector FSMs go to IDLE and all debounce/departure timers = 0.
  - rst has priority over every other event, including mid-debounce and mid-departure; nothing pending survives.
- Per-approach detector FSM, four identical instances, states IDLE, ARM, OCC, CLR; `cnt` is a 4-bit debounce counter.
  - IDLE: loop=1 -> ARM, cnt=1 (if DEB_CYC=1, go directly to OCC and count an arrival).
  - ARM: loop=0 -> IDLE with no arrival. loop=1 and cnt+1==DEB_CYC -> OCC with a one-cycle arrival pulse. Otherwise cnt++.
  - OCC: loop=0 -> CLR, cnt=1 (if DEB_CYC=1, go directly to IDLE).
  - CLR: loop=1 -> OCC with no new arrival. loop=0 and cnt+1==DEB_CYC -> IDLE. Otherwise cnt++.
  - Net effect: with DEB_CYC=3, loop sampled high on edges k, k+1, k+2 makes q increment at edge k+2.
- Departure, per approach:
  - Timer `dt` runs only while light==3'b100 and q>0; otherwise dt=0.
  - When dt+1==DEPART_CYC, a departure pulse is issued and dt=0; otherwise dt++.
  - Yellow, red, or an illegal code produce no departures.
- Queue update, per approach, at each edge:
  - arrival only: q = min(q+1, QMAX); if q was already QMAX, q_overflow is set.
  - departure only: q-1 (departure is impossible at q=0 by gating).
  - arrival and departure in the same cycle: q unchanged, no overflow.
- sensor_x is registered with q_x: it is updated at the same edge as q_x and equals (q_x != 0).
- lamp_fault is set at an edge where either condition holds on the sampled light codes:
  - any code is not in {001, 010, 100}, or
  - two or more codes equal 100.
  - All-red (emergency) is legal. Once set, lamp_fault stays set until rst.
- The four approaches are fully independent apart from the shared flags.
- No combinational path from inputs to outputs.

Test Plan:
- Reset check: assert rst for 2 cycles with loop_north=1 held -> all q_* = 0, all sensor_* = 0, both flags 0. Release rst; 3 edges later q_north = 1 and sensor_north = 1.
- Glitch rejection: loop_east pulses high for 2 cycles, low for 5, high for 2 -> q_east stays 0. A 1-cycle low dip while in OCC (vehicle over the loop) -> no second count.
- Arrival/departure: 4 north vehicles (each 4 high, 4 low), ns_light = red -> q_north = 4. Then ns_light = green for 6 cycles -> q_north = 1, with decrements every 2nd edge. Then yellow -> q_north holds at 1.
- Simultaneous events: with q_south = 2 and sn_light green, align an arrival's 3rd high sample with a departure edge -> q_south stays 2 at that edge.
- Saturation (QW = 5): 32 west arrivals with we_light red -> q_west = 31 and q_overflow = 1. Drive we_light green -> q_west decrements; q_overflow remains 1.
- Lamp fault: ns_light = 100 and ew_light = 100 for one cycle -> lamp_fault = 1, held after the codes return legal. Separately, ew_light = 011 -> lamp_fault = 1. All four codes = 001 -> no fault.
